// File: rtl/reg_bank_reader.sv
// reg_bank_reader: DEPTH x WIDTH register bank that streams a full dump on start.
// Option: REG_BANK_READER_CLEAR_ON_READ_EN clears each word as its transfer completes.
module reg_bank_reader #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             st,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] d,
    input  logic             start,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             o_ready,
    output logic             o_last,
    output logic             busy
);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    state_t           state;
    logic [AW-1:0]    rptr;
    logic [AW-1:0]    rptr_nxt;
    logic             xfer;

    assign rptr_nxt = rptr + AW'(1);
    assign xfer     = o_valid & o_ready;

    // A store on the transfer edge wins over the clear-on-read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
`ifdef REG_BANK_READER_CLEAR_ON_READ_EN
            if (xfer) begin
                mem[rptr] <= '0;
            end
`endif
            if (st) begin
                mem[waddr] <= d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rptr    <= '0;
            o_data  <= '0;
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state   <= SEND;
                        rptr    <= '0;
                        o_data  <= mem[0];
                        o_valid <= 1'b1;
                        o_last  <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                SEND: begin
                    if (xfer) begin
                        if (!o_last) begin
                            rptr   <= rptr_nxt;
                            o_data <= mem[rptr_nxt];
                            o_last <= (rptr_nxt == LAST_ADDR);
                        end else begin
                            state   <= IDLE;
                            o_valid <= 1'b0;
                            o_last  <= 1'b0;
                            busy    <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/reg_bank_reader.md
# reg_bank_reader

Storage bank of DEPTH words written through the same store-enable/data interface as the `d_flip_flop` cell (`st`, `d`, on `clk`). It is also the read side of that interface: on `start`, it streams every stored word out, in address order, over a valid/ready handshake. It sits between the memory cells and any consumer that needs a full dump of the bank.

## Interface
Parameters:
- WIDTH, 8, bits per word
- DEPTH, 8, number of words; power of two, >= 2
- AW, $clog2(DEPTH), address width; derived, not overridden

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- st  input  1  store enable; write `d` to `mem[waddr]` at the rising edge
- waddr  input  AW  write address
- d  input  WIDTH  write data
- start  input  1  request a full read-out; sampled only in IDLE
- o_data  output  WIDTH  word being offered
- o_valid  output  1  `o_data` is valid
- o_ready  input  1  consumer accepts the word
- o_last  output  1  the current word is `mem[DEPTH-1]`
- busy  output  1  a read-out is in progress

## Operation
- One clock (`clk`). Reset is asynchronous and active-low (`rst_n`).
- While `rst_n`=0:
  - every `mem` word is 0
  - state is IDLE, `rptr`=0
  - `o_data`=0, `o_valid`=0, `o_last`=0, `busy`=0
- Writes: `st`=1 writes `d` to `mem[waddr]` at the edge, in any state.
- FSM states: IDLE and SEND.
- IDLE with `start`=1 at edge N:
  - state becomes SEND, `busy`=1, `rptr`=0
  - `o_data` loads `mem[0]`, `o_valid`=1, `o_last`=0
- SEND, transfer (`o_valid`&`o_ready`) at an edge:
  - if `o_last`=0: `rptr` increments, `o_data` loads `mem[rptr+1]`, `o_last` is set to (`rptr+1`==DEPTH-1), `o_valid` stays 1.
  - if `o_last`=1: state becomes IDLE; `o_valid`, `o_last` and `busy` are cleared; `o_data` holds its last value.
- SEND with `o_ready`=0: `o_data`, `o_valid` and `o_last` hold. `o_valid` never drops before its transfer.
- `start` in SEND is ignored. It is not queued.
- `start` sampled in IDLE on the same edge that the last transfer completes: ignored, because the state was SEND at that edge.
- Snapshot rule: `o_data` is a register.
  - A write to the word currently offered does not change `o_data`.
  - A write to a word not yet loaded is seen when that word is loaded.
- Same-edge write and load of the same address: the load takes the old value; the write still lands in `mem`.
- Reset asserted mid-read-out: aborts immediately. All outputs and `mem` go to their reset values. No partial resume.

## Timing
- Latency from `start` to the first word: `o_valid`=1 in the cycle after the edge that sampled `start`.
- Throughput: one word per cycle while `o_ready`=1. A full dump takes DEPTH cycles from the first `o_valid`.
- `busy` equals `o_valid` in this design. Both are registered.
- `o_ready` may be high before `o_valid`. No combinational path from `o_ready` to any output.
- Write-to-read: data written at edge M is readable by a load at edge M+1 or later.

## Configuration
- `REG_BANK_READER_CLEAR_ON_READ_EN` defined:
  - each word is cleared to 0 in `mem` at the edge its transfer completes
  - a write with `st`=1 to the same address on that edge wins; `mem` gets `d`
- Not defined: reads are non-destructive and `mem` changes only on writes and reset.

## Test plan
- Reset, then write `mem[i]`=0x10+i for i=0..7, then start with `o_ready`=1:
  - `o_data` = 0x10..0x17 on consecutive cycles
  - `o_last`=1 only on 0x17
  - `busy`=0 the cycle after
- Backpressure: hold `o_ready`=0 for 3 cycles on word 2:
  - `o_data`=0x12 and `o_valid`=1 stable throughout
  - the sequence continues unchanged afterwards
- Write during read-out:
  - while word 1 is offered, write `mem[1]`=0xAA and `mem[5]`=0xBB
  - required: `o_data` stays 0x11 for word 1; word 5 is read as 0xBB
- Pulse `start` in SEND and on the final-transfer edge:
  - no restart
  - exactly 8 transfers occur
- Drop `rst_n` while word 4 is offered:
  - outputs are 0 immediately
  - after release, a new `start` reads 0x00 for every word
- With `REG_BANK_READER_CLEAR_ON_READ_EN`:
  - after one full dump, a second dump returns all 0x00
  - a write to `mem[3]`=0x33 on its transfer edge leaves `mem[3]`=0x33
